// File: rtl/jtag_tap_driver_if.sv
// Command/response port of the JTAG TAP driver.
// master: the management side issuing scan commands.
// slave : the TAP driver executing them.
//   cmd_valid/cmd_ready  request handshake, accept = cmd_valid & cmd_ready
//   cmd_op               00 RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE
//   cmd_len              shift length in bits, or TCK count for IDLE
//   cmd_data             TDI data, bit 0 shifted first
//   rsp_valid            one-clk completion pulse
//   rsp_data             captured TDO, first bit in bit 0
//   busy                 command in progress
interface jtag_tap_driver_if #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_tap_driver.sv
// On-chip JTAG initiator: runs TAP resets, IR/DR scans and idle clocking on
// the tck/tms/tdi/trst pins and returns captured tdo on a response port.
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   bus (slave)        command/response handshake (see jtag_tap_driver_if)
//   tck, tms, tdi      JTAG drive pins
//   trst               TAP reset, active-high
//   tdo                JTAG data from the TAP
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command, tck held low
// S_PRE   | TMS walk from Run-Test/Idle (or anywhere) into Shift-xR
// S_SHIFT | data bits (scan) or plain idle clocks
// S_POST  | TMS walk from Exit1-xR back to Run-Test/Idle
// S_DONE  | one cycle to publish the response
module jtag_tap_driver #(
  parameter int MAX_LEN = 64,
  parameter int DIV     = 2,
  parameter int LEN_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  jtag_tap_driver_if.slave bus,
  output logic             tck,
  output logic             tms,
  output logic             tdi,
  output logic             trst,
  input  logic             tdo
);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]    DIV_LD = DW'(DIV - 1);
  localparam logic [LEN_W-1:0] MAX_N  = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_DONE} state_t;

  state_t             state;
  logic [DW-1:0]      div_cnt;
  logic [2:0]         pre_left;
  logic [5:0]         pre_pat, trst_pat;
  logic [LEN_W-1:0]   sh_left, n_len;
  logic [1:0]         post_left, post_pat;
  logic [MAX_LEN-1:0] data_sr, tdo_sr, rsp_data_r;
  logic               scan, cmd_ready_r, busy_r, rsp_valid_r;

  // Command decode into pattern registers (TMS patterns are LSB first).
  logic [LEN_W-1:0] n_in, ld_sh_left;
  logic [2:0]       ld_pre_left;
  logic [5:0]       ld_pre_pat, ld_trst_pat;
  logic [1:0]       ld_post_left, ld_post_pat;
  logic             ld_scan;

  always_comb begin
    n_in         = (bus.cmd_len > MAX_N) ? MAX_N : bus.cmd_len;
    ld_pre_left  = '0;
    ld_pre_pat   = '0;
    ld_trst_pat  = '0;
    ld_sh_left   = '0;
    ld_post_left = '0;
    ld_post_pat  = '0;
    ld_scan      = 1'b0;
    case (bus.cmd_op)
      OP_RESET: begin
        ld_pre_left = 3'd6;
        ld_pre_pat  = 6'b011111;
        ld_trst_pat = 6'b011111;
      end
      OP_IR, OP_DR: if (n_in != '0) begin
        ld_pre_left  = (bus.cmd_op == OP_IR) ? 3'd4 : 3'd3;
        ld_pre_pat   = (bus.cmd_op == OP_IR) ? 6'b000011 : 6'b000001;
        ld_sh_left   = n_in;
        ld_post_left = 2'd2;
        ld_post_pat  = 2'b01;
        ld_scan      = 1'b1;
      end
      default: ld_sh_left = n_in;
    endcase
  end

  // Next-bit selection. At accept it works on the freshly decoded command,
  // otherwise on the remaining pattern registers.
  logic [2:0]         s_pre_left, nx_pre_left;
  logic [5:0]         s_pre_pat, s_trst_pat, nx_pre_pat, nx_trst_pat;
  logic [LEN_W-1:0]   s_sh_left, nx_sh_left;
  logic [1:0]         s_post_left, s_post_pat, nx_post_left, nx_post_pat;
  logic [MAX_LEN-1:0] s_data, nx_data;
  logic               s_scan, p_tms, p_tdi, p_trst, adv;
  state_t             p_state;

  always_comb begin
    if (state == S_IDLE) begin
      s_pre_left = ld_pre_left;   s_pre_pat  = ld_pre_pat;
      s_trst_pat = ld_trst_pat;   s_sh_left  = ld_sh_left;
      s_post_left = ld_post_left; s_post_pat = ld_post_pat;
      s_data = bus.cmd_data;      s_scan = ld_scan;
    end else begin
      s_pre_left = pre_left;      s_pre_pat  = pre_pat;
      s_trst_pat = trst_pat;      s_sh_left  = sh_left;
      s_post_left = post_left;    s_post_pat = post_pat;
      s_data = data_sr;           s_scan = scan;
    end
    nx_pre_left = s_pre_left;   nx_pre_pat  = s_pre_pat;
    nx_trst_pat = s_trst_pat;   nx_sh_left  = s_sh_left;
    nx_post_left = s_post_left; nx_post_pat = s_post_pat;
    nx_data = s_data;
    p_state = S_DONE;
    p_tms   = tms;
    p_tdi   = 1'b0;
    p_trst  = 1'b0;
    if (s_pre_left != '0) begin
      p_state     = S_PRE;
      p_tms       = s_pre_pat[0];
      p_trst      = s_trst_pat[0];
      nx_pre_left = s_pre_left - 3'd1;
      nx_pre_pat  = s_pre_pat >> 1;
      nx_trst_pat = s_trst_pat >> 1;
    end else if (s_sh_left != '0) begin
      p_state    = S_SHIFT;
      p_tms      = s_scan && (s_sh_left == LEN_W'(1));
      p_tdi      = s_scan & s_data[0];
      nx_sh_left = s_sh_left - LEN_W'(1);
      nx_data    = s_data >> 1;
    end else if (s_post_left != '0) begin
      p_state      = S_POST;
      p_tms        = s_post_pat[0];
      nx_post_left = s_post_left - 2'd1;
      nx_post_pat  = s_post_pat >> 1;
    end
  end

  // A new bit starts at accept, or when the high phase of the current bit ends.
  assign adv = (state == S_IDLE) ? bus.cmd_valid
             : ((state inside {S_PRE, S_SHIFT, S_POST}) && tck && (div_cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      pre_left    <= '0;
      pre_pat     <= '0;
      trst_pat    <= '0;
      sh_left     <= '0;
      n_len       <= '0;
      post_left   <= '0;
      post_pat    <= '0;
      data_sr     <= '0;
      tdo_sr      <= '0;
      scan        <= 1'b0;
      tck         <= 1'b0;
      tms         <= 1'b1;
      tdi         <= 1'b0;
      trst        <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
    end else begin
      rsp_valid_r <= 1'b0;
      if (adv) begin
        state     <= p_state;
        tck       <= 1'b0;
        div_cnt   <= DIV_LD;
        tms       <= p_tms;
        tdi       <= p_tdi;
        trst      <= p_trst;
        pre_left  <= nx_pre_left;
        pre_pat   <= nx_pre_pat;
        trst_pat  <= nx_trst_pat;
        sh_left   <= nx_sh_left;
        post_left <= nx_post_left;
        post_pat  <= nx_post_pat;
        data_sr   <= nx_data;
        if (state == S_IDLE) begin
          cmd_ready_r <= 1'b0;
          busy_r      <= 1'b1;
          scan        <= ld_scan;
          n_len       <= n_in;
          tdo_sr      <= '0;
        end
      end else if (state == S_DONE) begin
        state       <= S_IDLE;
        rsp_valid_r <= 1'b1;
        // Captured bits enter at the top; align the first one to bit 0.
        rsp_data_r  <= tdo_sr >> (MAX_LEN - int'(n_len));
        cmd_ready_r <= 1'b1;
        busy_r      <= 1'b0;
      end else if (state != S_IDLE) begin
        if (div_cnt != '0) begin
          div_cnt <= div_cnt - 1'b1;
        end else begin
          tck     <= 1'b1;
          div_cnt <= DIV_LD;
          if (state == S_SHIFT && scan) tdo_sr <= {tdo, tdo_sr[MAX_LEN-1:1]};
        end
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Testbench for jtag_tap_driver: behavioural TAP (IR length 4, IDCODE,
// BYPASS), command-level reference model feeding a scoreboard, and a
// monitor that checks each response plus the TCK/TMS/TRST trace.
module tb_jtag_tap_driver;
  localparam int MAX_LEN = 64;
  localparam int DIV     = 2;
  localparam int LEN_W   = 7;
  localparam logic [31:0] IDCODE    = 32'h1234_5677;
  localparam logic [3:0]  IR_IDCODE = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tck, tms, tdi, trst, tdo;

  jtag_tap_driver_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_tap_driver #(.MAX_LEN(MAX_LEN), .DIV(DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural TAP ----------------
  typedef enum int {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
                    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR} tap_t;
  tap_t ts = TLR;
  logic [3:0]  ir = IR_IDCODE;
  logic [3:0]  ir_sr = '0;
  logic [31:0] dr_sr = '0;
  logic        tdo_m = 1'b0;

  function automatic tap_t next_tap(input tap_t s, input logic m);
    case (s)
      TLR:    return m ? TLR    : RTI;
      RTI:    return m ? SEL_DR : RTI;
      SEL_DR: return m ? SEL_IR : CAP_DR;
      CAP_DR: return m ? EX1_DR : SH_DR;
      SH_DR:  return m ? EX1_DR : SH_DR;
      EX1_DR: return m ? UPD_DR : PAU_DR;
      PAU_DR: return m ? EX2_DR : PAU_DR;
      EX2_DR: return m ? UPD_DR : SH_DR;
      UPD_DR: return m ? SEL_DR : RTI;
      SEL_IR: return m ? TLR    : CAP_IR;
      CAP_IR: return m ? EX1_IR : SH_IR;
      SH_IR:  return m ? EX1_IR : SH_IR;
      EX1_IR: return m ? UPD_IR : PAU_IR;
      PAU_IR: return m ? EX2_IR : PAU_IR;
      EX2_IR: return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck or posedge trst) begin
    if (trst) begin
      ts <= TLR;
      ir <= IR_IDCODE;
    end else begin
      case (ts)
        TLR:    ir <= IR_IDCODE;
        CAP_DR: dr_sr <= (ir == IR_IDCODE) ? IDCODE : 32'h0;
        SH_DR:  dr_sr <= (ir == IR_IDCODE) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
        CAP_IR: ir_sr <= 4'b0001;
        SH_IR:  ir_sr <= {tdi, ir_sr[3:1]};
        UPD_IR: ir <= ir_sr;
        default: ;
      endcase
      ts <= next_tap(ts, tms);
    end
  end

  always @(negedge tck)
    tdo_m <= (ts == SH_DR) ? dr_sr[0] : (ts == SH_IR) ? ir_sr[0] : 1'b0;
  assign tdo = tdo_m;

  // Pin trace sampled at every TCK rise.
  bit tms_log[$];
  bit trst_log[$];
  always @(posedge tck) begin
    tms_log.push_back(tms);
    trst_log.push_back(trst);
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [63:0]  rsp;
    int           lat;
    int           t;
    logic [127:0] tms_e;
    logic [127:0] trst_e;
    logic [3:0]   ir;
    longint       acc;
    int           start;
  } exp_t;
  exp_t sb[$];
  logic [3:0] model_ir = IR_IDCODE;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lmask(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  // Expected outcome computed from the TAP protocol: TMS walks, chain
  // lengths and what falls out of the chain while n bits are pushed in.
  task automatic build_exp(input logic [1:0] op, input int len, input logic [63:0] data,
                           output exp_t e);
    int n;
    logic [67:0] v68;
    logic [95:0] v96;
    n = (len > 64) ? 64 : len;
    e.rsp = '0; e.t = 0; e.tms_e = '0; e.trst_e = '0;
    case (op)
      2'b00: begin
        e.t = 6;
        for (int k = 0; k < 5; k++) begin e.tms_e[k] = 1'b1; e.trst_e[k] = 1'b1; end
        model_ir = IR_IDCODE;
      end
      2'b01: if (n > 0) begin
        e.t = n + 6;
        e.tms_e[0] = 1'b1; e.tms_e[1] = 1'b1;
        e.tms_e[n+3] = 1'b1; e.tms_e[n+4] = 1'b1;
        v68 = {data, 4'b0001};
        e.rsp = v68[63:0] & lmask(n);
        model_ir = v68[n +: 4];
      end
      2'b10: if (n > 0) begin
        e.t = n + 5;
        e.tms_e[0] = 1'b1;
        e.tms_e[n+2] = 1'b1; e.tms_e[n+3] = 1'b1;
        v96 = (model_ir == IR_IDCODE) ? {data, IDCODE} : {31'h0, data, 1'b0};
        e.rsp = v96[63:0] & lmask(n);
      end
      default: e.t = n;
    endcase
    e.ir  = model_ir;
    e.lat = 2 * DIV * e.t + 1;
  endtask

  task automatic monitor();
    exp_t e;
    int hi;
    logic [127:0] a_tms, a_trst;
    hi = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hi = 0;
      end else begin
        if (tck) hi++;
        else begin
          if (hi != 0) chk("tck_high_len", 128'(hi), 128'(DIV));
          hi = 0;
        end
        chk("busy_vs_ready", bus.busy, !bus.cmd_ready);
        if (bus.rsp_valid) begin
          if (sb.size() == 0) chk("unexpected_rsp", bus.rsp_valid, 1'b0);
          else begin
            e = sb.pop_front();
            a_tms = '0; a_trst = '0;
            for (int k = 0; k < e.t && k < 128; k++)
              if (e.start + k < tms_log.size()) begin
                a_tms[k]  = tms_log[e.start + k];
                a_trst[k] = trst_log[e.start + k];
              end
            chk("rsp_data", bus.rsp_data, e.rsp);
            chk("latency", 128'(cyc - e.acc), 128'(e.lat));
            chk("tck_rises", 128'(tms_log.size() - e.start), 128'(e.t));
            chk("tms_trace", a_tms, e.tms_e);
            chk("trst_trace", a_trst, e.trst_e);
            chk("tap_in_rti", ts == RTI, 1'b1);
            chk("tap_ir", ir, e.ir);
            chk("ready_with_rsp", bus.cmd_ready, 1'b1);
            chk("tck_low_at_rsp", tck, 1'b0);
          end
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic do_cmd(input logic [1:0] op, input int len, input logic [63:0] data);
    exp_t e;
    int w;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_data  = data;
    w = 0;
    while (!bus.cmd_ready && w < 2000) begin @(negedge clk); w++; end
    if (!bus.cmd_ready) begin
      chk("accept_timeout", bus.cmd_ready, 1'b1);
    end else begin
      build_exp(op, len, data, e);
      e.acc   = cyc + 1;
      e.start = tms_log.size();
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic release_cmd();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_len   = LEN_W'($urandom);
    bus.cmd_data  = {$urandom, $urandom};
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 5000) begin @(negedge clk); w++; end
    chk("drain", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    int s, w, len, sel;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    #1 rst = 1'b1;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_tck", tck, 1'b0);
    chk("rst_tms", tms, 1'b1);
    chk("rst_tdi", tdi, 1'b0);
    chk("rst_trst", trst, 1'b0);
    chk("rst_ready", bus.cmd_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 64'h0);
    rst = 1'b0;

    do_cmd(2'b00, 0, 64'h0);          release_cmd();
    do_cmd(2'b10, 32, 64'h0);         release_cmd();
    do_cmd(2'b01, 4, 64'b0010);       release_cmd();
    do_cmd(2'b10, 32, {$urandom, $urandom}); release_cmd();
    do_cmd(2'b10, 0, {$urandom, $urandom});  release_cmd();
    do_cmd(2'b10, 100, {$urandom, $urandom}); release_cmd();
    do_cmd(2'b11, 5, {$urandom, $urandom});  release_cmd();
    do_cmd(2'b11, 0, 64'h0);          release_cmd();
    do_cmd(2'b01, 0, 64'hF);          release_cmd();

    // back-to-back: cmd_valid stays high while busy
    do_cmd(2'b10, 32, {$urandom, $urandom});
    do_cmd(2'b10, 40, {$urandom, $urandom});
    do_cmd(2'b01, 4, 64'b1111);
    do_cmd(2'b10, 9, {$urandom, $urandom});
    release_cmd();

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      len = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(65, 127) : $urandom_range(1, 64);
      do_cmd(2'($urandom_range(0, 3)), len, {$urandom, $urandom});
      if ($urandom_range(0, 2) != 0) release_cmd();
    end
    release_cmd();
    drain();

    // async reset in the middle of a DR scan
    do_cmd(2'b00, 0, 64'h0); release_cmd();
    drain();
    s = tms_log.size();
    do_cmd(2'b10, 32, {$urandom, $urandom}); release_cmd();
    w = 0;
    while (tms_log.size() < s + 13 && w < 500) begin @(negedge clk); w++; end
    chk("abort_reach_bit10", 128'(tms_log.size() >= s + 13), 128'(1));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_tck", tck, 1'b0);
    chk("abort_tms", tms, 1'b1);
    chk("abort_tdi", tdi, 1'b0);
    chk("abort_trst", trst, 1'b0);
    chk("abort_ready", bus.cmd_ready, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_rsp_data", bus.rsp_data, 64'h0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    do_cmd(2'b00, 0, 64'h0);  release_cmd();
    do_cmd(2'b10, 32, 64'h0); release_cmd();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
